multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath. It replaces single-cycle opcode decoding with a state machine that walks each instruction through fetch, decode, execute, memory and writeback. It sits between the instruction register's opcode field and the shared datapath muxes, ALU, register file and unified memory. Memory accesses use a ready handshake, so the controller stalls for variable-latency memory.

---
 rtl/multicycle_pkg.sv | 78 +++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/mc_output_decode.sv | 97 +++++++++
 rtl/multicycle_control.sv | 90 +++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer.
// Contents: the state encoding, the supported opcodes, the ALUOp/ALUSrcB/PCSource
// field encodings, the internal control bundle, and the DECODE dispatch helper.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_RTYPE2 = 6'h2A;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_J      = 6'h02;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       lui;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // State that DECODE dispatches to; S_FETCH marks an unsupported opcode.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE, OP_RTYPE2: nxt = S_EXEC;
      OP_LW, OP_SW:        nxt = S_MEMADR;
      OP_BEQ, OP_BNE:      nxt = S_BRANCH;
      OP_ADDI, OP_LUI:     nxt = S_IEXEC;
      OP_J:                nxt = S_JUMP;
      default:             nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the sequencer and the datapath.
// master: the sequencer (reads opcode/mem_ready, drives control + state).
// slave:  the datapath/memory side (drives opcode/mem_ready, reads controls).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       LUI;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, LUI, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, LUI, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Purely combinational control decode for the multi-cycle sequencer.
// Ports: state (current FSM state), opcode (IR[31:26]), mem_ready (memory
// handshake) -> ctrl (full control bundle). Anything not named for a state is 0.
module mc_output_decode
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control outputs; FETCH and MEMWR are Mealy on mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is dispatched.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        if (decode_target(opcode) == S_FETCH) begin
          ctrl.illegal    = 1'b1;
          ctrl.instr_done = 1'b1;
        end else begin
          ctrl.illegal    = 1'b0;
          ctrl.instr_done = 1'b0;
        end
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.lui        = (opcode == OP_LUI);
        ctrl.instr_done = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Ports: clk, reset (synchronous, active-high), bus (master modport):
//   in  opcode, mem_ready; out datapath controls, instr_done, illegal, state.
// While reset is high every output, including state, is forced to 0.
module multicycle_control
  import multicycle_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t state_r;
  state_t state_nxt_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;

  mc_output_decode u_output_decode (
    .state     (state_r),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_s)
  );

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; mem_ready only matters in FETCH, MEMRD and MEMWR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) state_nxt_s = S_DECODE;
        else               state_nxt_s = S_FETCH;
      end
      S_DECODE: state_nxt_s = decode_target(bus.opcode);
      S_EXEC:   state_nxt_s = S_RWB;
      S_MEMADR: begin
        if (bus.opcode == OP_SW) state_nxt_s = S_MEMWR;
        else                     state_nxt_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_nxt_s = S_MEMWB;
        else               state_nxt_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_nxt_s = S_FETCH;
        else               state_nxt_s = S_MEMWR;
      end
      S_IEXEC:  state_nxt_s = S_IWB;
      S_RWB, S_MEMWB, S_BRANCH, S_JUMP, S_IWB: state_nxt_s = S_FETCH;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // Blank every control during reset so no write strobe escapes that cycle.
  always_comb begin
    if (reset) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign bus.PCWrite     = ctrl_out_s.pc_write;
  assign bus.PCWriteCond = ctrl_out_s.pc_write_cond;
  assign bus.BranchNE    = ctrl_out_s.branch_ne;
  assign bus.IorD        = ctrl_out_s.iord;
  assign bus.MemRead     = ctrl_out_s.mem_read;
  assign bus.MemWrite    = ctrl_out_s.mem_write;
  assign bus.IRWrite     = ctrl_out_s.ir_write;
  assign bus.MemtoReg    = ctrl_out_s.mem_to_reg;
  assign bus.RegDst      = ctrl_out_s.reg_dst;
  assign bus.RegWrite    = ctrl_out_s.reg_write;
  assign bus.LUI         = ctrl_out_s.lui;
  assign bus.ALUSrcA     = ctrl_out_s.alu_src_a;
  assign bus.ALUSrcB     = ctrl_out_s.alu_src_b;
  assign bus.ALUOp       = ctrl_out_s.alu_op;
  assign bus.PCSource    = ctrl_out_s.pc_source;
  assign bus.instr_done  = ctrl_out_s.instr_done;
  assign bus.illegal     = ctrl_out_s.illegal;
  assign bus.state       = reset ? 4'd0 : state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs on the falling
// edge, queues the expected state and control word, then pops and compares
// before the next rising edge.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout used for expectations.
  localparam logic [19:0] F_PCW     = 20'h80000;
  localparam logic [19:0] F_PCWC    = 20'h40000;
  localparam logic [19:0] F_BNE     = 20'h20000;
  localparam logic [19:0] F_IORD    = 20'h10000;
  localparam logic [19:0] F_MRD     = 20'h08000;
  localparam logic [19:0] F_MWR     = 20'h04000;
  localparam logic [19:0] F_IRW     = 20'h02000;
  localparam logic [19:0] F_M2R     = 20'h01000;
  localparam logic [19:0] F_RDST    = 20'h00800;
  localparam logic [19:0] F_RW      = 20'h00400;
  localparam logic [19:0] F_LUI     = 20'h00200;
  localparam logic [19:0] F_SRCA    = 20'h00100;
  localparam logic [19:0] SRCB_4    = 20'h00040;
  localparam logic [19:0] SRCB_IMM  = 20'h00080;
  localparam logic [19:0] SRCB_SH   = 20'h000C0;
  localparam logic [19:0] OP_SUB    = 20'h00010;
  localparam logic [19:0] OP_ADD    = 20'h00020;
  localparam logic [19:0] PCS_OUT   = 20'h00004;
  localparam logic [19:0] PCS_J     = 20'h00008;
  localparam logic [19:0] F_DONE    = 20'h00002;
  localparam logic [19:0] F_ILL     = 20'h00001;

  localparam logic [19:0] V_FETCH_STALL = F_MRD | SRCB_4 | OP_ADD;
  localparam logic [19:0] V_FETCH       = F_MRD | SRCB_4 | OP_ADD | F_IRW | F_PCW;
  localparam logic [19:0] V_DECODE      = SRCB_SH | OP_ADD;
  localparam logic [19:0] V_DECODE_ILL  = SRCB_SH | OP_ADD | F_ILL | F_DONE;
  localparam logic [19:0] V_EXEC        = F_SRCA;
  localparam logic [19:0] V_RWB         = F_RDST | F_RW | F_DONE;
  localparam logic [19:0] V_MEMADR      = F_SRCA | SRCB_IMM | OP_ADD;
  localparam logic [19:0] V_MEMRD       = F_IORD | F_MRD;
  localparam logic [19:0] V_MEMWB       = F_M2R | F_RW | F_DONE;
  localparam logic [19:0] V_MEMWR_STALL = F_IORD | F_MWR;
  localparam logic [19:0] V_MEMWR       = F_IORD | F_MWR | F_DONE;
  localparam logic [19:0] V_BEQ         = F_SRCA | OP_SUB | F_PCWC | PCS_OUT | F_DONE;
  localparam logic [19:0] V_BNE         = F_SRCA | OP_SUB | F_PCWC | PCS_OUT | F_DONE | F_BNE;
  localparam logic [19:0] V_JUMP        = F_PCW | PCS_J | F_DONE;
  localparam logic [19:0] V_IEXEC       = F_SRCA | SRCB_IMM | OP_ADD;
  localparam logic [19:0] V_IWB         = F_RW | F_DONE;
  localparam logic [19:0] V_IWB_LUI     = F_RW | F_DONE | F_LUI;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [19:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  function automatic logic [19:0] observed_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.BranchNE, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
            bus.LUI, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.instr_done, bus.illegal};
  endfunction

  task automatic check_front();
    exp_t        e;
    logic [19:0] ov;
    logic [3:0]  os;
    e  = sb.pop_front();
    ov = observed_vec();
    os = bus.state;
    n_cmp++;
    assert (os === e.st) else begin
      n_err++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, os, e.st);
    end
    n_cmp++;
    assert (ov === e.vec) else begin
      n_err++;
      $error("FAIL %s ctrl: observed %05h expected %05h", e.tag, ov, e.vec);
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] es, input logic [19:0] ev, input string tag);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    e.tag = tag;
    e.st  = es;
    e.vec = ev;
    sb.push_back(e);
    #2;
    check_front();
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;

    // Reset holds everything at zero.
    step(1'b1, 6'h00, 1'b0, 4'd0, 20'h00000, "reset0");
    step(1'b1, 6'h23, 1'b1, 4'd0, 20'h00000, "reset1");

    // R-type 0x00: 0,1,6,7.
    step(1'b0, 6'h00, 1'b1, 4'd0, V_FETCH,  "r_fetch");
    step(1'b0, 6'h00, 1'b1, 4'd1, V_DECODE, "r_decode");
    step(1'b0, 6'h00, 1'b1, 4'd6, V_EXEC,   "r_exec");
    step(1'b0, 6'h00, 1'b1, 4'd7, V_RWB,    "r_rwb");

    // R-type 0x2A back to back.
    step(1'b0, 6'h2A, 1'b1, 4'd0, V_FETCH,  "r2_fetch");
    step(1'b0, 6'h2A, 1'b1, 4'd1, V_DECODE, "r2_decode");
    step(1'b0, 6'h2A, 1'b1, 4'd6, V_EXEC,   "r2_exec");
    step(1'b0, 6'h2A, 1'b1, 4'd7, V_RWB,    "r2_rwb");

    // lw with two stall cycles in MEMRD; mem_ready low in MEMADR is ignored.
    step(1'b0, 6'h23, 1'b1, 4'd0, V_FETCH,  "lw_fetch");
    step(1'b0, 6'h23, 1'b1, 4'd1, V_DECODE, "lw_decode");
    step(1'b0, 6'h23, 1'b0, 4'd2, V_MEMADR, "lw_memadr");
    step(1'b0, 6'h23, 1'b0, 4'd3, V_MEMRD,  "lw_memrd_stall0");
    step(1'b0, 6'h23, 1'b0, 4'd3, V_MEMRD,  "lw_memrd_stall1");
    step(1'b0, 6'h23, 1'b1, 4'd3, V_MEMRD,  "lw_memrd_done");
    step(1'b0, 6'h23, 1'b1, 4'd4, V_MEMWB,  "lw_memwb");

    // sw with one FETCH stall and one MEMWR stall.
    step(1'b0, 6'h2B, 1'b0, 4'd0, V_FETCH_STALL, "sw_fetch_stall");
    step(1'b0, 6'h2B, 1'b1, 4'd0, V_FETCH,       "sw_fetch");
    step(1'b0, 6'h2B, 1'b1, 4'd1, V_DECODE,      "sw_decode");
    step(1'b0, 6'h2B, 1'b1, 4'd2, V_MEMADR,      "sw_memadr");
    step(1'b0, 6'h2B, 1'b0, 4'd5, V_MEMWR_STALL, "sw_memwr_stall");
    step(1'b0, 6'h2B, 1'b1, 4'd5, V_MEMWR,       "sw_memwr_done");

    // bne then beq, 3 cycles each.
    step(1'b0, 6'h05, 1'b1, 4'd0, V_FETCH,  "bne_fetch");
    step(1'b0, 6'h05, 1'b1, 4'd1, V_DECODE, "bne_decode");
    step(1'b0, 6'h05, 1'b1, 4'd8, V_BNE,    "bne_branch");
    step(1'b0, 6'h04, 1'b1, 4'd0, V_FETCH,  "beq_fetch");
    step(1'b0, 6'h04, 1'b1, 4'd1, V_DECODE, "beq_decode");
    step(1'b0, 6'h04, 1'b1, 4'd8, V_BEQ,    "beq_branch");

    // lui then j, no bubble between them.
    step(1'b0, 6'h0F, 1'b1, 4'd0,  V_FETCH,   "lui_fetch");
    step(1'b0, 6'h0F, 1'b1, 4'd1,  V_DECODE,  "lui_decode");
    step(1'b0, 6'h0F, 1'b1, 4'd10, V_IEXEC,   "lui_iexec");
    step(1'b0, 6'h0F, 1'b1, 4'd11, V_IWB_LUI, "lui_iwb");
    step(1'b0, 6'h02, 1'b1, 4'd0,  V_FETCH,   "j_fetch");
    step(1'b0, 6'h02, 1'b1, 4'd1,  V_DECODE,  "j_decode");
    step(1'b0, 6'h02, 1'b1, 4'd9,  V_JUMP,    "j_jump");

    // addi: IWB without LUI.
    step(1'b0, 6'h08, 1'b1, 4'd0,  V_FETCH,  "addi_fetch");
    step(1'b0, 6'h08, 1'b1, 4'd1,  V_DECODE, "addi_decode");
    step(1'b0, 6'h08, 1'b1, 4'd10, V_IEXEC,  "addi_iexec");
    step(1'b0, 6'h08, 1'b1, 4'd11, V_IWB,    "addi_iwb");

    // Illegal opcode: 2 cycles, back to FETCH.
    step(1'b0, 6'h3F, 1'b1, 4'd0, V_FETCH,      "ill_fetch");
    step(1'b0, 6'h3F, 1'b1, 4'd1, V_DECODE_ILL, "ill_decode");
    step(1'b0, 6'h3F, 1'b0, 4'd0, V_FETCH_STALL, "ill_refetch");

    // Reset in the middle of a stalled MEMRD.
    step(1'b0, 6'h23, 1'b1, 4'd0, V_FETCH,       "rst_lw_fetch");
    step(1'b0, 6'h23, 1'b1, 4'd1, V_DECODE,      "rst_lw_decode");
    step(1'b0, 6'h23, 1'b1, 4'd2, V_MEMADR,      "rst_lw_memadr");
    step(1'b0, 6'h23, 1'b0, 4'd3, V_MEMRD,       "rst_lw_memrd");
    step(1'b1, 6'h23, 1'b1, 4'd0, 20'h00000,     "rst_mid");
    step(1'b0, 6'h23, 1'b0, 4'd0, V_FETCH_STALL, "rst_after");
    step(1'b0, 6'h23, 1'b1, 4'd0, V_FETCH,       "rst_after_fetch");
    step(1'b0, 6'h23, 1'b1, 4'd1, V_DECODE,      "rst_after_decode");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
